mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the 6502 core, one DMA requester and the single-port RAM.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface mem_bus_arbiter_if;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_addr, cpu_rw, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_addr, dma_rw, dma_wdata,
    output dma_gnt, dma_ack, dma_rdata,
    output mem_addr, mem_rw, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_addr, cpu_rw, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_addr, dma_rw, dma_wdata,
    input  dma_gnt, dma_ack, dma_rdata,
    input  mem_addr, mem_rw, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the M6502 (stalled via ready) and a DMA requester.
// Define ARB_STATS_EN to add saturating stall_cycles / dma_cycles counters.
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CPU_GAP   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_bus_arbiter_if.slave        bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             dma_cycles
`endif
);
  localparam logic [8:0] MAX_B = 9'(MAX_BURST);
  localparam logic [7:0] GAP   = 8'(CPU_GAP);

  typedef enum logic [1:0] {ST_CPU, ST_HOLD, ST_DMA} state_t;

  state_t      state, state_nxt;
  logic        ready, ready_nxt;
  logic        gnt, gnt_nxt;
  logic        ack, ack_nxt;
  logic [7:0]  rdata, rdata_nxt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic [7:0]  gap_cnt, gap_nxt;
  logic [7:0]  gap_dec;

  // RAM-side mux keyed only on the registered grant
  assign bus.mem_addr  = gnt ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_rw    = gnt ? bus.dma_rw    : bus.cpu_rw;
  assign bus.mem_wdata = gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_ready = ready;
  assign bus.dma_gnt   = gnt;
  assign bus.dma_ack   = ack;
  assign bus.dma_rdata = rdata;

  assign gap_dec = (gap_cnt == 8'd0) ? 8'd0 : gap_cnt - 8'd1;

  always_comb begin
    state_nxt = state;
    ready_nxt = ready;
    gnt_nxt   = gnt;
    ack_nxt   = 1'b0;
    rdata_nxt = rdata;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    unique case (state)
      ST_CPU: begin
        gap_nxt = gap_dec;
        // The CPU-owned cycle being spent right now counts toward the gap.
        if (bus.dma_req && gap_dec == 8'd0) begin
          state_nxt = ST_HOLD;
          ready_nxt = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!bus.dma_req) begin
          state_nxt = ST_CPU;
          ready_nxt = 1'b1;
        end else if (bus.cpu_rw) begin
          state_nxt = ST_DMA;
          gnt_nxt   = 1'b1;
          burst_nxt = 8'd0;
        end
      end
      ST_DMA: begin
        if (bus.dma_req) begin
          ack_nxt   = 1'b1;
          burst_nxt = burst_cnt + 8'd1;
          if (bus.dma_rw) rdata_nxt = bus.mem_rdata;
        end
        if (!bus.dma_req || ({1'b0, burst_cnt} + 9'd1 >= MAX_B)) begin
          state_nxt = ST_CPU;
          gnt_nxt   = 1'b0;
          ready_nxt = 1'b1;
          gap_nxt   = GAP;
        end
      end
      default: begin
        state_nxt = ST_CPU;
        gnt_nxt   = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CPU;
      ready     <= 1'b1;
      gnt       <= 1'b0;
      ack       <= 1'b0;
      rdata     <= 8'd0;
      burst_cnt <= 8'd0;
      gap_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      ready     <= ready_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      rdata     <= rdata_nxt;
      burst_cnt <= burst_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic access;
  assign access = (state == ST_DMA) && bus.dma_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      dma_cycles   <= 32'd0;
    end else begin
      if (!ready) stall_cycles <= sat_inc(stall_cycles);
      if (access) dma_cycles   <= sat_inc(dma_cycles);
    end
  end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-cycle vector table, DMA ack scoreboard and
// hand-written reset / read / burst-cap / mid-burst-reset sequences.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_ack = 0;

  mem_bus_arbiter_if bus();
`ifdef ARB_STATS_EN
  logic [31:0] stall_cycles, dma_cycles;
`endif

  mem_bus_arbiter #(.MAX_BURST(8), .CPU_GAP(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef ARB_STATS_EN
    , .stall_cycles(stall_cycles), .dma_cycles(dma_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_rw == 1'b0) ram[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: one entry per DMA access, retired by the matching ack.
  typedef struct packed { logic rd; logic [7:0] data; } sb_t;
  sb_t  sbq[$];
  sb_t  sb_e;
  logic prev_acc = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.dma_ack === 1'b1 || prev_acc)
        check("ack_timing", 32'(bus.dma_ack), 32'(prev_acc));
      if (bus.dma_ack === 1'b1) begin
        n_ack++;
        if (sbq.size() == 0) check("ack_unexpected", 32'(bus.dma_ack), 0);
        else begin
          sb_e = sbq.pop_front();
          if (sb_e.rd) check("sb_rdata", 32'(bus.dma_rdata), 32'(sb_e.data));
        end
      end
      prev_acc <= (bus.dma_gnt === 1'b1) && (bus.dma_req === 1'b1) && (reset === 1'b0);
      if ((bus.dma_gnt === 1'b1) && (bus.dma_req === 1'b1) && (reset === 1'b0))
        sbq.push_back('{bus.dma_rw, ram[bus.dma_addr]});
    end
  end

  typedef struct {
    logic [15:0] caddr; logic crw; logic [7:0] cwd;
    logic req; logic [15:0] daddr; logic drw; logic [7:0] dwd;
    logic e_ready; logic e_gnt; logic [15:0] e_maddr; logic e_mrw; logic [7:0] e_mwd;
  } vec_t;
  localparam int NV = 17;
  vec_t vt [NV];

  task automatic drive(input logic [15:0] caddr, input logic crw, input logic [7:0] cwd,
                       input logic req, input logic [15:0] daddr, input logic drw,
                       input logic [7:0] dwd);
    bus.cpu_addr = caddr; bus.cpu_rw = crw; bus.cpu_wdata = cwd;
    bus.dma_req = req; bus.dma_addr = daddr; bus.dma_rw = drw; bus.dma_wdata = dwd;
  endtask

  task automatic wait_gnt(input string nm);
    int k = 0;
    #1;
    while (bus.dma_gnt !== 1'b1 && k < 20) begin tick(); #1; k++; end
    check(nm, 32'(bus.dma_gnt), 1);
  endtask

  int base_ack;

  initial begin
    ram[16'h1234] = 8'h5A; ram[16'h0300] = 8'h77;
    ram[16'h0500] = 8'h3C; ram[16'h0600] = 8'hC3;
    //                  caddr   crw  cwd    req daddr  drw  dwd   | rdy gnt maddr   mrw  mwd
    vt[0]  = '{16'h8000,1'b1,8'h00, 1'b1,16'h0200,1'b0,8'hA5, 1'b1,1'b0,16'h8000,1'b1,8'h00};
    vt[1]  = '{16'h8000,1'b1,8'h00, 1'b1,16'h0200,1'b0,8'hA5, 1'b0,1'b0,16'h8000,1'b1,8'h00};
    vt[2]  = '{16'h8000,1'b1,8'h00, 1'b1,16'h0200,1'b0,8'hA5, 1'b0,1'b1,16'h0200,1'b0,8'hA5};
    vt[3]  = '{16'h8000,1'b1,8'h00, 1'b0,16'h0200,1'b1,8'hA5, 1'b0,1'b1,16'h0200,1'b1,8'hA5};
    vt[4]  = '{16'h8000,1'b1,8'h00, 1'b0,16'h0000,1'b1,8'h00, 1'b1,1'b0,16'h8000,1'b1,8'h00};
    vt[5]  = '{16'h8100,1'b1,8'h00, 1'b0,16'h0000,1'b1,8'h00, 1'b1,1'b0,16'h8100,1'b1,8'h00};
    vt[6]  = '{16'h8100,1'b1,8'h00, 1'b1,16'h0300,1'b1,8'h00, 1'b1,1'b0,16'h8100,1'b1,8'h00};
    vt[7]  = '{16'h01FF,1'b0,8'h30, 1'b1,16'h0300,1'b1,8'h00, 1'b0,1'b0,16'h01FF,1'b0,8'h30};
    vt[8]  = '{16'h01FE,1'b0,8'h31, 1'b1,16'h0300,1'b1,8'h00, 1'b0,1'b0,16'h01FE,1'b0,8'h31};
    vt[9]  = '{16'h01FD,1'b0,8'h32, 1'b1,16'h0300,1'b1,8'h00, 1'b0,1'b0,16'h01FD,1'b0,8'h32};
    vt[10] = '{16'hFFFE,1'b1,8'h00, 1'b1,16'h0300,1'b1,8'h00, 1'b0,1'b0,16'hFFFE,1'b1,8'h00};
    vt[11] = '{16'hFFFE,1'b1,8'h00, 1'b1,16'h0300,1'b1,8'h00, 1'b0,1'b1,16'h0300,1'b1,8'h00};
    vt[12] = '{16'hFFFE,1'b1,8'h00, 1'b0,16'h0300,1'b1,8'h00, 1'b0,1'b1,16'h0300,1'b1,8'h00};
    vt[13] = '{16'hFFFE,1'b1,8'h00, 1'b0,16'h0300,1'b1,8'h00, 1'b1,1'b0,16'hFFFE,1'b1,8'h00};
    vt[14] = '{16'h8200,1'b1,8'h00, 1'b1,16'h0400,1'b1,8'h00, 1'b1,1'b0,16'h8200,1'b1,8'h00};
    vt[15] = '{16'h8200,1'b1,8'h00, 1'b0,16'h0400,1'b1,8'h00, 1'b0,1'b0,16'h8200,1'b1,8'h00};
    vt[16] = '{16'h8200,1'b1,8'h00, 1'b0,16'h0400,1'b1,8'h00, 1'b1,1'b0,16'h8200,1'b1,8'h00};

    // Reset held two edges with a pending DMA request
    drive(16'hFFFC, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b1, 8'h00);
    tick(); tick();
    #1;
    check("rst_ready", 32'(bus.cpu_ready), 1);
    check("rst_gnt",   32'(bus.dma_gnt), 0);
    check("rst_ack",   32'(bus.dma_ack), 0);
    check("rst_maddr", 32'(bus.mem_addr), 'hFFFC);
    reset = 1'b0;
    bus.dma_req = 1'b0;
    mon_en = 1'b1;
    tick(); tick();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].caddr, vt[i].crw, vt[i].cwd, vt[i].req, vt[i].daddr, vt[i].drw, vt[i].dwd);
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(bus.cpu_ready), 32'(vt[i].e_ready));
      check($sformatf("tbl%0d_gnt", i),   32'(bus.dma_gnt),   32'(vt[i].e_gnt));
      check($sformatf("tbl%0d_maddr", i), 32'(bus.mem_addr),  32'(vt[i].e_maddr));
      check($sformatf("tbl%0d_mrw", i),   32'(bus.mem_rw),    32'(vt[i].e_mrw));
      check($sformatf("tbl%0d_mwd", i),   32'(bus.mem_wdata), 32'(vt[i].e_mwd));
      tick();
    end
    check("ram_0200", 32'(ram[16'h0200]), 'hA5);
    check("ram_01FF", 32'(ram[16'h01FF]), 'h30);
    check("ram_01FE", 32'(ram[16'h01FE]), 'h31);
    check("ram_01FD", 32'(ram[16'h01FD]), 'h32);

    // DMA read; CPU must come back on the address it stalled on
    drive(16'hC000, 1'b1, 8'h00, 1'b1, 16'h1234, 1'b1, 8'h00);
    wait_gnt("rd_gnt");
    tick();
    bus.dma_req = 1'b0;
    #1;
    check("rd_ack",  32'(bus.dma_ack), 1);
    check("rd_data", 32'(bus.dma_rdata), 'h5A);
    tick();
    #1;
    check("rd_ready", 32'(bus.cpu_ready), 1);
    check("rd_gnt_off", 32'(bus.dma_gnt), 0);
    check("rd_resume", 32'(bus.mem_addr), 'hC000);
    tick(); tick();

    // Burst cap: 8 accesses, one CPU cycle, HOLD, repeat (period 10)
    base_ack = n_ack;
    drive(16'h9000, 1'b1, 8'h00, 1'b1, 16'h0500, 1'b1, 8'h00);
    for (int c = 0; c < 30; c++) begin
      #1;
      check($sformatf("burst%0d_ready", c), 32'(bus.cpu_ready), ((c % 10) == 0) ? 1 : 0);
      check($sformatf("burst%0d_gnt", c),   32'(bus.dma_gnt),   ((c % 10) >= 2) ? 1 : 0);
      tick();
    end
    bus.dma_req = 1'b0;
    #1;
    check("burst_exit_ready", 32'(bus.cpu_ready), 1);
    tick();
    check("burst_acks", n_ack - base_ack, 24);
    tick();

    // Reset after three accesses of a burst
    drive(16'h9100, 1'b1, 8'h00, 1'b1, 16'h0600, 1'b1, 8'h00);
    wait_gnt("mid_gnt");
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dma_req = 1'b0;
    #1;
    check("mid_gnt_off", 32'(bus.dma_gnt), 0);
    check("mid_ready",   32'(bus.cpu_ready), 1);
    check("mid_ack",     32'(bus.dma_ack), 0);
`ifdef ARB_STATS_EN
    check("mid_stall_cnt", stall_cycles, 0);
    check("mid_dma_cnt",   dma_cycles, 0);
`endif
    tick();
    #1;
    check("mid_ack_after", 32'(bus.dma_ack), 0);
    tick(); tick();

    check("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
